// File: rtl/rca_seq_adder_pkg.sv
// Shared types and sizing helpers for the sequential ripple-carry adder.
package rca_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Total operand width for a given slice width and slice count.
  function automatic int unsigned calc_w(input int unsigned size, input int unsigned words);
    return size * words;
  endfunction

  // Slice counter width: enough to reach WORDS-1, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_adder_rca.sv
// Plain N-bit ripple-carry adder with no carry-in; used as the single slice adder.
module rca #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] s_o,
  output logic         co_o
);

  logic c;

  // Ripple the carry bit by bit through a chain of full adders.
  always_comb begin
    s_o = '0;
    c   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    co_o = c;
  end

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle adder: adds two SIZE*WORDS-bit operands one SIZE-bit slice per
// cycle, LSB slice first, carrying between slices in a register.
module rca_seq_adder
  import rca_seq_pkg::*;
#(
  parameter int unsigned SIZE  = 2,
  parameter int unsigned WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE*WORDS-1:0]   op_a,
  input  logic [SIZE*WORDS-1:0]   op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE*WORDS:0]     sum,
  output logic                    busy
);

  localparam int unsigned W     = calc_w(SIZE, WORDS);
  localparam int unsigned CNT_W = calc_cnt_w(WORDS);

  state_e             state_q, state_d;
  logic [W-1:0]       a_sh_q, a_sh_d;
  logic [W-1:0]       b_sh_q, b_sh_d;
  logic [W:0]         sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SIZE:0]      slice_a, slice_b, slice_s;
  logic               slice_co;
  logic [SIZE+1:0]    r;
  logic [W+SIZE-1:0]  sum_shift;
  logic               last;

  // Slice operands: the forced 1 in A's LSB paired with the carry in B's LSB
  // generates the carry into bit 1, so the adder needs no dedicated carry-in.
  always_comb begin
    slice_a = {a_sh_q[SIZE-1:0], 1'b1};
    slice_b = {b_sh_q[SIZE-1:0], carry_q};
    r       = {slice_co, slice_s};
    last    = (cnt_q == CNT_W'(WORDS - 1));
  end

  rca #(
    .N (SIZE + 1)
  ) u_rca (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last slice,
  // DONE -> IDLE once the sum is consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded directly from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
  end

  // Datapath next-state: capture in IDLE, shift one slice per RUN cycle.
  always_comb begin
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    // Concatenate-then-slice keeps the shift valid even when W == SIZE.
    sum_shift = {r[SIZE:1], sum_q[W-1:0]};
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d[W-1:0] = sum_shift[W+SIZE-1:SIZE];
        carry_d      = r[SIZE+1];
        a_sh_d       = a_sh_q >> SIZE;
        b_sh_d       = b_sh_q >> SIZE;
        if (last) sum_d[W] = r[SIZE+1];
        else      cnt_d    = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder at default parameters (SIZE=2, WORDS=4).
module tb_rca_seq_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a, op_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rca_seq_adder #(
    .SIZE  (2),
    .WORDS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .busy      (busy)
  );

  // Stimulus helper: wait (bounded) for in_ready, present operands for one edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid (bounded at 20).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (sum !== 9'h000) begin fails++; $display("FAIL reset_sum got=%h exp=000", sum); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'hA5, 8'hFF};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h5A, 8'hFF};
    logic [8:0] ve [4] = '{9'h000, 9'h100, 9'h0FF, 9'h1FE};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL basic_busy[%0d] busy=%b in_ready=%b exp=1/0", i, busy, in_ready); end
      wait_valid(n);
      tests++; if (n != 4) begin fails++; $display("FAIL basic_latency[%0d] got=%0d exp=4", i, n); end
      tests++; if (sum !== ve[i]) begin fails++; $display("FAIL basic_sum[%0d] got=%h exp=%h", i, sum, ve[i]); end
      consume;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL basic_release[%0d] out_valid=%b in_ready=%b exp=0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_stall;
    int n;
    start_op(8'h12, 8'h34);
    wait_valid(n);
    tests++; if (sum !== 9'h046) begin fails++; $display("FAIL stall_sum got=%h exp=046", sum); end
    op_a = 8'h11; op_b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || sum !== 9'h046 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] out_valid=%b sum=%h in_ready=%b exp=1/046/0", i, out_valid, sum, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL stall_idle in_ready=%b busy=%b exp=1/0", in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    tests++; if (n != 4) begin fails++; $display("FAIL stall_pending_latency got=%0d exp=4", n); end
    tests++; if (sum !== 9'h033) begin fails++; $display("FAIL stall_pending_sum got=%h exp=033", sum); end
    consume;
  endtask

  task automatic test_out_ready_high;
    int n;
    out_ready = 1'b1;
    start_op(8'h80, 8'h80);
    wait_valid(n);
    tests++; if (n != 4) begin fails++; $display("FAIL ordy_latency got=%0d exp=4", n); end
    tests++; if (sum !== 9'h100) begin fails++; $display("FAIL ordy_sum got=%h exp=100", sum); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ordy_one_cycle out_valid=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    logic seen;
    start_op(8'hFF, 8'hFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 9'h000) begin
      fails++; $display("FAIL rmid_async busy=%b in_ready=%b out_valid=%b sum=%h exp=0/1/0/000", busy, in_ready, out_valid, sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rmid_no_valid seen=%b exp=0", seen); end
    start_op(8'h01, 8'h01);
    wait_valid(n);
    tests++; if (sum !== 9'h002 || n != 4) begin fails++; $display("FAIL rmid_next sum=%h lat=%0d exp=002/4", sum, n); end
    consume;
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic [8:0] exp;
    int n;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      start_op(a, b);
      wait_valid(n);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      tests++;
      if (out_valid !== 1'b1 || sum !== exp) begin
        fails++; $display("FAIL rand[%0d] %h+%h sum=%h out_valid=%b exp=%h/1", i, a, b, sum, out_valid, exp);
      end
      consume;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_out_ready_high;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
